// File: rtl/dpram_hs.sv
// dpram_hs: simple dual-port RAM for hiscore tables.
// Port A is write-only and port B is read-only with a registered output.
// After reset the whole array is zero-filled, and busy_o stays high until the fill completes.
module dpram_hs #(
    parameter int unsigned addr_width_g = 8,
    parameter int unsigned data_width_g = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_a_i,
    input  logic [addr_width_g-1:0] addr_a_i,
    input  logic [data_width_g-1:0] data_a_i,
    input  logic [addr_width_g-1:0] addr_b_i,
    output logic [data_width_g-1:0] data_b_o,
    output logic                    busy_o
);

    localparam int unsigned AW    = addr_width_g;
    localparam int unsigned DW    = data_width_g;
    localparam int unsigned DEPTH = 2 ** addr_width_g;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   ptr_q;
    logic [AW-1:0]   ptr_d;
    logic            busy_q;
    logic [DW-1:0]   data_b_q;

    logic            wr_en_c;
    logic [AW-1:0]   wr_addr_c;
    logic [DW-1:0]   wr_data_c;

    logic [DW-1:0]   mem_q [DEPTH];

    assign ptr_d    = ptr_q + AW'(1);
    assign busy_o   = busy_q;
    assign data_b_o = data_b_q;

    // Clear sequencer: walk the pointer to all-ones, then hand over to normal operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == '1) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_d;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Write-port mux: the clear pointer owns the write port until the fill is done.
    always_comb begin
        wr_en_c   = we_a_i;
        wr_addr_c = addr_a_i;
        wr_data_c = data_a_i;
        if (state_q == ST_CLEAR) begin
            wr_en_c   = 1'b1;
            wr_addr_c = ptr_q;
            wr_data_c = '0;
        end
    end

    // Array write. The array has no reset so that it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem_q[wr_addr_c] <= wr_data_c;
        end
    end

    // Registered read with read-before-write behaviour. The output is forced to 0 while clearing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_b_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            data_b_q <= '0;
        end else begin
            data_b_q <= mem_q[addr_b_i];
        end
    end

endmodule

// File: tb/tb_dpram_hs.sv
// Scoreboard bench for dpram_hs: a 4-bit/24-bit instance and an 8-bit/8-bit instance share one clock.
module tb_dpram_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: addr 4, data 24
    logic        rst_a = 1'b1;
    logic        we_a = 1'b0;
    logic [3:0]  wa_a = '0;
    logic [23:0] wd_a = '0;
    logic [3:0]  ra_a = '0;
    logic [23:0] dout_a;
    logic        busy_a;

    // instance B: addr 8, data 8
    logic        rst_b = 1'b1;
    logic        we_b = 1'b0;
    logic [7:0]  wa_b = '0;
    logic [7:0]  wd_b = '0;
    logic [7:0]  ra_b = '0;
    logic [7:0]  dout_b;
    logic        busy_b;

    int n_cmp = 0;
    int n_err = 0;

    logic        chk_a = 1'b0;
    logic        chk_b = 1'b0;
    logic [23:0] qa [$];
    logic [7:0]  qb [$];

    dpram_hs #(.addr_width_g(4), .data_width_g(24)) u_a (
        .clk_i(clk), .rst_i(rst_a), .we_a_i(we_a), .addr_a_i(wa_a),
        .data_a_i(wd_a), .addr_b_i(ra_a), .data_b_o(dout_a), .busy_o(busy_a)
    );

    dpram_hs #(.addr_width_g(8), .data_width_g(8)) u_b (
        .clk_i(clk), .rst_i(rst_b), .we_a_i(we_b), .addr_a_i(wa_b),
        .data_a_i(wd_b), .addr_b_i(ra_b), .data_b_o(dout_b), .busy_o(busy_b)
    );

    // Monitor for A: checks one cycle after every flagged read.
    always @(posedge clk) begin
        if (chk_a) begin
            #1;
            n_cmp++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL sb_a_underflow: read seen with no expected value");
            end else begin
                logic [23:0] e;
                e = qa.pop_front();
                if (dout_a !== e) begin
                    n_err++;
                    $display("FAIL sb_a_read addr=%0d got=%h expected=%h", ra_a, dout_a, e);
                end
            end
        end
    end

    // Monitor for B.
    always @(posedge clk) begin
        if (chk_b) begin
            #1;
            n_cmp++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL sb_b_underflow: read seen with no expected value");
            end else begin
                logic [7:0] e;
                e = qb.pop_front();
                if (dout_b !== e) begin
                    n_err++;
                    $display("FAIL sb_b_read got=%h expected=%h", dout_b, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // One cycle on port A/B of instance A; an optional read pushes its expected word.
    task automatic cyc_a(input bit we, input logic [3:0] wa, input logic [23:0] wd,
                         input bit rd, input logic [3:0] ra, input logic [23:0] exp);
        @(negedge clk);
        we_a = we; wa_a = wa; wd_a = wd; ra_a = ra; chk_a = rd;
        if (rd) qa.push_back(exp);
    endtask

    task automatic cyc_b(input bit we, input logic [7:0] wa, input logic [7:0] wd,
                         input bit rd, input logic [7:0] ra, input logic [7:0] exp);
        @(negedge clk);
        we_b = we; wa_b = wa; wd_b = wd; ra_b = ra; chk_b = rd;
        if (rd) qb.push_back(exp);
    endtask

    task automatic wait_idle_a(input int budget);
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle_a busy=%b after %0d cycles, required 0", busy_a, n);
        end
    endtask

    task automatic wait_idle_b(input int budget);
        int n;
        n = 0;
        while (busy_b === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle_b busy=%b after %0d cycles, required 0", busy_b, n);
        end
    endtask

    initial begin
        // Reset state, instance A
        repeat (2) @(negedge clk);
        check("rst_a_data", 32'(dout_a), 32'h0);
        check("rst_a_busy", 32'(busy_a), 32'h1);

        // Clear sequence: 16 edges, with a write to address 3 attempted while busy
        we_a = 1'b1; wa_a = 4'd3; wd_a = 24'h000077;
        rst_a = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 8) begin
                check("clear_data_held0", 32'(dout_a), 32'h0);
                we_a = 1'b0;
            end
            if (i == 15) check("busy_edge15", 32'(busy_a), 32'h1);
            if (i == 16) check("busy_edge16", 32'(busy_a), 32'h0);
        end

        // Every address reads 0, including address 3 after the ignored write
        for (int i = 0; i < 16; i++) cyc_a(1'b0, '0, '0, 1'b1, 4'(i), 24'h0);

        // 24-bit write/read
        cyc_a(1'b1, 4'd0, 24'h000B0F, 1'b0, 4'd0, 24'h0);
        cyc_a(1'b1, 4'd1, 24'h00230F, 1'b0, 4'd0, 24'h0);
        cyc_a(1'b0, 4'd0, 24'h0,      1'b1, 4'd0, 24'h000B0F);
        cyc_a(1'b0, 4'd0, 24'h0,      1'b1, 4'd1, 24'h00230F);

        // Same-address collision returns the old word
        cyc_a(1'b1, 4'd5, 24'h0000AA, 1'b0, 4'd0, 24'h0);
        cyc_a(1'b1, 4'd5, 24'h000055, 1'b1, 4'd5, 24'h0000AA);
        cyc_a(1'b0, 4'd0, 24'h0,      1'b1, 4'd5, 24'h000055);

        // Async reset mid-operation
        cyc_a(1'b1, 4'd7, 24'h000012, 1'b0, 4'd0, 24'h0);
        cyc_a(1'b0, 4'd0, 24'h0,      1'b1, 4'd7, 24'h000012);
        cyc_a(1'b0, 4'd0, 24'h0,      1'b0, 4'd7, 24'h0);
        #2 rst_a = 1'b1;
        #1;
        check("async_rst_data", 32'(dout_a), 32'h0);
        check("async_rst_busy", 32'(busy_a), 32'h1);
        @(negedge clk);
        rst_a = 1'b0;
        wait_idle_a(40);
        cyc_a(1'b0, 4'd0, 24'h0, 1'b1, 4'd7, 24'h0);
        cyc_a(1'b0, 4'd0, 24'h0, 1'b1, 4'd5, 24'h0);
        cyc_a(1'b0, 4'd0, 24'h0, 1'b0, 4'd0, 24'h0);

        // Full-depth sweep on instance B
        rst_b = 1'b0;
        wait_idle_b(400);
        for (int i = 0; i < 256; i++) cyc_b(1'b1, 8'(i), 8'(i), 1'b0, '0, '0);
        for (int i = 0; i < 256; i++) cyc_b(1'b0, '0, '0, 1'b1, 8'(i), 8'(i));
        cyc_b(1'b0, '0, '0, 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        check("sb_a_drained", 32'(qa.size()), 32'h0);
        check("sb_b_drained", 32'(qb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
